// File: rtl/prim_intr_coalesce.sv
// Multi-channel interrupt handler: event/status channels, optional rising-edge sources,
// and a coalescing engine that fires irq_o on an event-count threshold or a timeout.
module prim_intr_coalesce #(
    parameter int unsigned      Width      = 8,
    parameter logic [Width-1:0] IntrType   = '0,
    parameter logic [Width-1:0] EdgeDetect = '0,
    parameter int unsigned      CntW       = 8,
    parameter bit               FlopOutput = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] event_intr_i,
    input  logic [Width-1:0] reg2hw_intr_enable_q_i,
    input  logic [Width-1:0] reg2hw_intr_test_q_i,
    input  logic             reg2hw_intr_test_qe_i,
    input  logic [Width-1:0] reg2hw_intr_state_q_i,
    output logic             hw2reg_intr_state_de_o,
    output logic [Width-1:0] hw2reg_intr_state_d_o,
    input  logic [CntW-1:0]  coal_thresh_i,
    input  logic [CntW-1:0]  coal_timeout_i,
    output logic [Width-1:0] intr_o,
    output logic             irq_o,
    output logic [CntW-1:0]  coal_cnt_o
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StFire    = 2'd2
    } state_e;

    localparam logic [CntW-1:0] CntOne = CntW'(1);

    function automatic logic [CntW-1:0] popcnt(input logic [Width-1:0] v);
        logic [CntW-1:0] c;
        c = '0;
        for (int i = 0; i < Width; i++) begin
            c = c + CntW'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [CntW-1:0] sat_add(input logic [CntW-1:0] a,
                                                 input logic [CntW-1:0] b);
        logic [CntW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CntW] ? {CntW{1'b1}} : s[CntW-1:0];
    endfunction

    logic [Width-1:0] prev_q;
    logic [Width-1:0] new_ev_s;
    logic [Width-1:0] state_d_s;
    logic [CntW-1:0]  inc_s, thr_s, cnt_sum_s, timer_inc_s;
    logic             pend_s;
    state_e           st_q;
    logic [CntW-1:0]  cnt_q, timer_q;
    logic             irq_q;

    // Source history for rising-edge channels.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= '0;
        end else begin
            prev_q <= event_intr_i;
        end
    end

    // New events, INTR_STATE next value and coalescing increments.
    always_comb begin
        new_ev_s    = (event_intr_i & ~(EdgeDetect & prev_q))
                    | ({Width{reg2hw_intr_test_qe_i}} & reg2hw_intr_test_q_i);
        state_d_s   = (IntrType & new_ev_s) | (~IntrType & (reg2hw_intr_state_q_i | new_ev_s));
        inc_s       = popcnt(new_ev_s & reg2hw_intr_enable_q_i);
        pend_s      = |(reg2hw_intr_state_q_i & reg2hw_intr_enable_q_i);
        thr_s       = (coal_thresh_i == '0) ? CntOne : coal_thresh_i;
        cnt_sum_s   = sat_add(cnt_q, inc_s);
        timer_inc_s = sat_add(timer_q, CntOne);
    end

    assign hw2reg_intr_state_d_o  = state_d_s;
    assign hw2reg_intr_state_de_o = (|(new_ev_s & ~IntrType))
                                  | (|((state_d_s ^ reg2hw_intr_state_q_i) & IntrType));

    // Coalescing FSM; firing wins over the all-cleared exit in COLLECT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q    <= StIdle;
            cnt_q   <= '0;
            timer_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            case (st_q)
                StIdle: begin
                    if (inc_s != '0) begin
                        cnt_q <= inc_s;
                        if (inc_s >= thr_s) begin
                            st_q  <= StFire;
                            irq_q <= 1'b1;
                        end else begin
                            st_q <= StCollect;
                        end
                    end
                end
                StCollect: begin
                    timer_q <= timer_inc_s;
                    cnt_q   <= cnt_sum_s;
                    if ((cnt_sum_s >= thr_s) ||
                        ((coal_timeout_i != '0) && (timer_inc_s >= coal_timeout_i))) begin
                        st_q  <= StFire;
                        irq_q <= 1'b1;
                    end else if (!pend_s && (inc_s == '0)) begin
                        st_q    <= StIdle;
                        cnt_q   <= '0;
                        timer_q <= '0;
                    end
                end
                StFire: begin
                    cnt_q <= cnt_sum_s;
                    if (!pend_s && (inc_s == '0)) begin
                        st_q    <= StIdle;
                        irq_q   <= 1'b0;
                        cnt_q   <= '0;
                        timer_q <= '0;
                    end
                end
                default: begin
                    st_q    <= StIdle;
                    irq_q   <= 1'b0;
                    cnt_q   <= '0;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign irq_o      = irq_q;
    assign coal_cnt_o = cnt_q;

    if (FlopOutput) begin : g_flop_out
        logic [Width-1:0] intr_q;
        // Registered per-channel interrupt outputs.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                intr_q <= '0;
            end else begin
                intr_q <= reg2hw_intr_state_q_i & reg2hw_intr_enable_q_i;
            end
        end
        assign intr_o = intr_q;
    end else begin : g_comb_out
        assign intr_o = reg2hw_intr_state_q_i & reg2hw_intr_enable_q_i;
    end

endmodule

// File: tb/tb_prim_intr_coalesce.sv
// Randomized and directed bench for prim_intr_coalesce against a behavioural model that
// also plays the register file holding INTR_STATE.
module tb_prim_intr_coalesce;

    localparam logic [3:0] ITYPE = 4'b1000;
    localparam logic [3:0] EDET  = 4'b0010;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ev, en, tq, rf_state, sw_clr;
    logic       tqe;
    logic [7:0] thresh, tmo;
    logic       de_o, irq_o;
    logic [3:0] d_o, intr_o;
    logic [7:0] cnt_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n_de     = 0;

    // Model state
    logic [3:0] m_prev, m_intr;
    int         m_cnt, m_timer;
    bit         m_active, m_irq;
    logic [3:0] x_new, x_d;
    bit         x_de, x_pend;
    int         x_inc;

    prim_intr_coalesce #(
        .Width(4), .IntrType(ITYPE), .EdgeDetect(EDET), .CntW(8), .FlopOutput(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .event_intr_i(ev),
        .reg2hw_intr_enable_q_i(en), .reg2hw_intr_test_q_i(tq),
        .reg2hw_intr_test_qe_i(tqe), .reg2hw_intr_state_q_i(rf_state),
        .hw2reg_intr_state_de_o(de_o), .hw2reg_intr_state_d_o(d_o),
        .coal_thresh_i(thresh), .coal_timeout_i(tmo),
        .intr_o(intr_o), .irq_o(irq_o), .coal_cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_reset();
        m_prev = '0; m_intr = '0; m_cnt = 0; m_timer = 0;
        m_active = 1'b0; m_irq = 1'b0; rf_state = '0;
    endtask

    task automatic model_comb();
        x_de = 1'b0; x_inc = 0;
        for (int i = 0; i < 4; i++) begin
            x_new[i] = (EDET[i] ? (ev[i] & ~m_prev[i]) : ev[i]) | (tqe & tq[i]);
            x_d[i]   = ITYPE[i] ? x_new[i] : (rf_state[i] | x_new[i]);
            if (ITYPE[i] ? (x_d[i] != rf_state[i]) : x_new[i]) x_de = 1'b1;
            if (x_new[i] && en[i]) x_inc++;
        end
        x_pend = |(rf_state & en);
    endtask

    task automatic model_seq();
        int thr, t, c;
        thr = (thresh == 8'd0) ? 1 : int'(thresh);
        m_intr = rf_state & en;
        m_prev = ev;
        if (!m_active) begin
            if (x_inc > 0) begin
                m_active = 1'b1; m_cnt = x_inc; m_timer = 0; m_irq = (x_inc >= thr);
            end
        end else begin
            t = sat(m_timer + 1);
            c = sat(m_cnt + x_inc);
            m_cnt = c;
            if (!m_irq) m_timer = t;
            if (!m_irq && (c >= thr || (tmo != 8'd0 && t >= int'(tmo)))) begin
                m_irq = 1'b1;
            end else if (!x_pend && x_inc == 0) begin
                m_active = 1'b0; m_irq = 1'b0; m_cnt = 0; m_timer = 0;
            end
        end
        rf_state = (x_de ? x_d : rf_state) & ~sw_clr;
    endtask

    task automatic cycle();
        @(negedge clk);
        model_comb();
        check_eq("de", de_o, x_de);
        check_eq("d", d_o, x_d);
        check_eq("irq", irq_o, m_irq);
        check_eq("cnt", cnt_o, m_cnt[7:0]);
        check_eq("intr", intr_o, m_intr);
        if (de_o) n_de++;
        @(posedge clk);
        #1;
        model_seq();
        sw_clr = '0;
    endtask

    task automatic drain();
        ev = '0; tqe = 1'b0; sw_clr = 4'hf;
        cycle();
        repeat (3) cycle();
    endtask

    initial begin
        int first;
        rst = 1'b1; ev = '0; en = '0; tq = '0; tqe = 1'b0; sw_clr = '0;
        thresh = 8'd1; tmo = 8'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_irq", irq_o, 1'b0);
        check_eq("rst_cnt", cnt_o, 8'd0);
        check_eq("rst_intr", intr_o, 4'd0);
        rst = 1'b0;

        // Single pulse, threshold 1, then software clear
        en = 4'hf;
        ev = 4'b0100;
        cycle();
        check_eq("t1_irq_rise", irq_o, 1'b1);
        ev = '0;
        cycle();
        check_eq("t1_intr", intr_o, 4'b0100);
        sw_clr = 4'b0100;
        cycle();
        cycle();
        check_eq("t1_irq_clear", irq_o, 1'b0);
        drain();

        // Count threshold 3, events spread across three channels
        thresh = 8'd3; tmo = 8'd0;
        for (int c = 0; c <= 9; c++) begin
            ev = (c == 0) ? 4'b0001 : (c == 5) ? 4'b0010 : (c == 9) ? 4'b1000 : 4'b0000;
            cycle();
            if (c == 0) check_eq("t2_cnt1", cnt_o, 8'd1);
            if (c == 5) check_eq("t2_cnt2", cnt_o, 8'd2);
            if (c == 8) check_eq("t2_irq_low", irq_o, 1'b0);
        end
        check_eq("t2_cnt3", cnt_o, 8'd3);
        check_eq("t2_irq_c10", irq_o, 1'b1);
        drain();

        // Timeout forces the fire
        thresh = 8'd8; tmo = 8'd20; first = -1;
        for (int k = 0; k < 40; k++) begin
            ev = (k == 0) ? 4'b0001 : 4'b0000;
            cycle();
            if (irq_o && first < 0) first = k;
        end
        check_eq("t3_fire_cycle", first + 1, 21);
        drain();

        // Edge-detect channel held high, status channel follows level
        n_de = 0;
        ev = 4'b1010;
        repeat (10) cycle();
        check_eq("t4_one_de", n_de, 1);
        check_eq("t4_status_level", intr_o, 4'b1010);
        drain();

        // Test-register injection with partial enable
        thresh = 8'd5; tmo = 8'd0; en = 4'b0001;
        tq = 4'b1001; tqe = 1'b1;
        cycle();
        tqe = 1'b0;
        check_eq("t5_cnt", cnt_o, 8'd1);
        cycle();
        check_eq("t5_intr", intr_o, 4'b0001);
        en = 4'hf;
        drain();

        // Asynchronous reset in the middle of collecting
        ev = 4'b0001; cycle();
        ev = 4'b0100; cycle();
        ev = '0;
        check_eq("t6_cnt_before", cnt_o, 8'd2);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_cnt_async", cnt_o, 8'd0);
        check_eq("t6_irq_async", irq_o, 1'b0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        ev = 4'b0001; cycle();
        ev = '0;
        check_eq("t6_cnt_after", cnt_o, 8'd1);
        drain();

        // Randomized traffic
        for (int k = 0; k < 2000; k++) begin
            ev = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            if ($urandom_range(0, 49) == 0) en = 4'($urandom);
            if ($urandom_range(0, 99) == 0) thresh = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 99) == 0) tmo = 8'($urandom_range(0, 15));
            tqe = ($urandom_range(0, 29) == 0);
            tq = 4'($urandom);
            sw_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
            cycle();
        end
        tqe = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
